// File: rtl/sig_debounce.sv
// Board-input conditioner: synchronises a raw pin, qualifies changes over a programmable
// number of time-base ticks, and reports clean level, edge pulses and a rejected-glitch count.
module sig_debounce #(
    parameter int unsigned CNTR_NBITS   = 5,
    parameter logic        DEF_OUTPUT   = 1'b0,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GLITCH_NBITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNTR_NBITS-1:0]   cnt_size,
    input  logic                    cnt_step,
    input  logic                    signal_in,
    input  logic                    glitch_clr,
    output logic                    signal_out,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic                    stable,
    output logic [GLITCH_NBITS-1:0] glitch_cnt
);

    typedef enum logic {
        StStable = 1'b0,
        StQual   = 1'b1
    } state_e;

    localparam logic [GLITCH_NBITS-1:0] GlitchMax = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNTR_NBITS-1:0]  timer_q;
    logic                   timer_done;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{DEF_OUTPUT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // >= rather than == so a cnt_size lowered below the running timer accepts immediately.
    assign timer_done = (timer_q >= cnt_size);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StStable;
            timer_q    <= '0;
            signal_out <= DEF_OUTPUT;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            unique case (state_q)
                StStable: begin
                    timer_q <= '0;
                    if (s != signal_out) begin
                        state_q <= StQual;
                    end
                end
                StQual: begin
                    if (s == signal_out) begin
                        state_q <= StStable;
                        timer_q <= '0;
                        if (glitch_cnt != GlitchMax) begin
                            glitch_cnt <= glitch_cnt + 1'b1;
                        end
                    end else if (cnt_step && timer_done) begin
                        signal_out <= s;
                        rise_pulse <= s;
                        fall_pulse <= ~s;
                        state_q    <= StStable;
                        timer_q    <= '0;
                    end else if (cnt_step) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StStable;
                    timer_q <= '0;
                end
            endcase
            // Clear overrides a same-cycle increment by being the last assignment.
            if (glitch_clr) begin
                glitch_cnt <= '0;
            end
        end
    end

    assign stable = (state_q == StStable);

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: fixed vector table, directed corner sequences, and random
// stimulus checked every cycle against an abstract reference model.
module tb_sig_debounce;

    localparam int unsigned CNTR_NBITS   = 5;
    localparam logic        DEF_OUTPUT   = 1'b0;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned GLITCH_NBITS = 8;
    localparam int          GMAX         = (1 << GLITCH_NBITS) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [CNTR_NBITS-1:0]   cnt_size;
    logic                    cnt_step;
    logic                    signal_in;
    logic                    glitch_clr;
    logic                    signal_out;
    logic                    rise_pulse;
    logic                    fall_pulse;
    logic                    stable;
    logic [GLITCH_NBITS-1:0] glitch_cnt;

    sig_debounce #(
        .CNTR_NBITS  (CNTR_NBITS),
        .DEF_OUTPUT  (DEF_OUTPUT),
        .SYNC_STAGES (SYNC_STAGES),
        .GLITCH_NBITS(GLITCH_NBITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_size  (cnt_size),
        .cnt_step  (cnt_step),
        .signal_in (signal_in),
        .glitch_clr(glitch_clr),
        .signal_out(signal_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .stable    (stable),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a delay line for the synchroniser, a "waiting" flag with an unbounded
    // count of ticks seen, and a glitch tally clipped to the counter's maximum.
    bit m_pipe[$];
    bit m_out;
    bit m_rise;
    bit m_fall;
    bit m_waiting;
    int m_ticks;
    int m_glitches;

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(DEF_OUTPUT);
        m_out = DEF_OUTPUT;
        m_rise = 0;
        m_fall = 0;
        m_waiting = 0;
        m_ticks = 0;
        m_glitches = 0;
    endtask

    task automatic model_step();
        bit seen;
        if (reset) begin
            model_reset();
            return;
        end
        seen = m_pipe[SYNC_STAGES-1];
        m_pipe.push_front(signal_in);
        void'(m_pipe.pop_back());
        m_rise = 0;
        m_fall = 0;
        if (!m_waiting) begin
            if (seen != m_out) begin
                m_waiting = 1;
                m_ticks = 0;
            end
        end else if (seen == m_out) begin
            m_waiting = 0;
            m_glitches = (m_glitches < GMAX) ? m_glitches + 1 : GMAX;
        end else if (cnt_step && m_ticks >= int'(cnt_size)) begin
            m_out = seen;
            m_rise = seen;
            m_fall = !seen;
            m_waiting = 0;
        end else if (cnt_step) begin
            m_ticks++;
        end
        if (glitch_clr) m_glitches = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs and compare every output to the model.
    task automatic cycle();
        logic [GLITCH_NBITS+3:0] got;
        logic [GLITCH_NBITS+3:0] exp;
        model_step();
        @(posedge clk);
        #1;
        got = {signal_out, rise_pulse, fall_pulse, stable, glitch_cnt};
        exp = {m_out, m_rise, m_fall, !m_waiting, GLITCH_NBITS'(m_glitches)};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL model t=%0t: got out/rise/fall/stable/glitch=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     $time, got[GLITCH_NBITS+3], got[GLITCH_NBITS+2], got[GLITCH_NBITS+1],
                     got[GLITCH_NBITS], got[GLITCH_NBITS-1:0], exp[GLITCH_NBITS+3],
                     exp[GLITCH_NBITS+2], exp[GLITCH_NBITS+1], exp[GLITCH_NBITS],
                     exp[GLITCH_NBITS-1:0]);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        signal_in = 0;
        cnt_step = 0;
        glitch_clr = 0;
        cycle();
        reset = 0;
    endtask

    typedef struct {
        logic       rst;
        logic       din;
        logic       step;
        logic [4:0] size;
        logic       clr;
        logic       e_out;
        logic       e_rise;
        logic       e_fall;
        logic       e_stable;
        int         e_glitch;
    } vec_t;

    vec_t tbl[18];
    int   rise_cnt;
    int   rise_idx;
    bit   saw_qual;
    bit   done;
    int   n;

    initial begin
        reset = 1;
        signal_in = 0;
        cnt_step = 0;
        cnt_size = 0;
        glitch_clr = 0;
        model_reset();

        // rst din step size clr | out rise fall stable glitch
        tbl[0]  = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0};
        tbl[8]  = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0};
        tbl[9]  = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 1};
        tbl[11] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0};
        tbl[13] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[14] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[15] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[17] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst;
            signal_in = tbl[i].din;
            cnt_step = tbl[i].step;
            cnt_size = tbl[i].size;
            glitch_clr = tbl[i].clr;
            cycle();
            check($sformatf("tbl%0d.out", i), int'(signal_out), int'(tbl[i].e_out));
            check($sformatf("tbl%0d.rise", i), int'(rise_pulse), int'(tbl[i].e_rise));
            check($sformatf("tbl%0d.fall", i), int'(fall_pulse), int'(tbl[i].e_fall));
            check($sformatf("tbl%0d.stable", i), int'(stable), int'(tbl[i].e_stable));
            check($sformatf("tbl%0d.glitch", i), int'(glitch_cnt), tbl[i].e_glitch);
        end

        // Quiet input after reset release.
        do_reset();
        rise_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (rise_pulse || fall_pulse || !stable) rise_cnt++;
        end
        check("idle.activity", rise_cnt, 0);
        check("idle.out", int'(signal_out), 0);

        // cnt_size=3, tick every 4th cycle, held rising input.
        do_reset();
        cnt_size = 3;
        signal_in = 1;
        rise_cnt = 0;
        rise_idx = -1;
        saw_qual = 0;
        for (int i = 0; i < 40; i++) begin
            cnt_step = (i % 4 == 3);
            cycle();
            if (rise_pulse) begin
                rise_cnt++;
                rise_idx = i;
            end
            if (i == 2 && !stable) saw_qual = 1;
        end
        check("rise.count", rise_cnt, 1);
        check("rise.cycle", rise_idx, 14 + SYNC_STAGES - 1);
        check("rise.qual_unstable", int'(saw_qual), 1);
        check("rise.out", int'(signal_out), 1);

        // Input high for only two ticks: rejected as a glitch.
        do_reset();
        cnt_size = 3;
        rise_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            signal_in = (i < 8);
            cnt_step = (i % 4 == 3);
            cycle();
            if (rise_pulse) rise_cnt++;
        end
        check("short.rise", rise_cnt, 0);
        check("short.out", int'(signal_out), 0);
        check("short.glitch", int'(glitch_cnt), 1);
        check("short.stable", int'(stable), 1);

        // Saturation after 260 glitches, then clear racing an increment.
        do_reset();
        cnt_size = 10;
        cnt_step = 0;
        for (int g = 0; g < 260; g++) begin
            for (int k = 0; k < 4; k++) begin
                signal_in = (k == 0);
                cycle();
            end
        end
        check("sat.glitch", int'(glitch_cnt), GMAX);
        for (int k = 0; k < 4; k++) begin
            signal_in = (k == 0);
            glitch_clr = (k == 3);
            cycle();
        end
        glitch_clr = 0;
        check("sat.clear_wins", int'(glitch_cnt), 0);

        // Lowering cnt_size below the running timer accepts on the next tick.
        do_reset();
        cnt_size = 10;
        cnt_step = 1;
        signal_in = 1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            if (signal_out) done = 1;
        end
        check("lower.rise_seen", int'(done), 1);
        signal_in = 0;
        cnt_step = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            cycle();
            if (!stable) done = 1;
        end
        check("lower.qual_seen", int'(done), 1);
        cnt_step = 1;
        for (int i = 0; i < 6; i++) cycle();
        check("lower.still_high", int'(signal_out), 1);
        cnt_size = 2;
        cycle();
        check("lower.fall", int'(fall_pulse), 1);
        check("lower.out", int'(signal_out), 0);
        cnt_step = 0;
        cycle();
        check("lower.fall_once", int'(fall_pulse), 0);

        // cnt_size=0 with cnt_step tied high.
        do_reset();
        cnt_size = 0;
        cnt_step = 1;
        signal_in = 1;
        n = 0;
        done = 0;
        for (int i = 1; i <= 10 && !done; i++) begin
            cycle();
            if (signal_out) begin
                n = i;
                done = 1;
            end
        end
        check("zero.latency", n, SYNC_STAGES + 2);

        // Reset in the middle of qualification.
        do_reset();
        cnt_size = 10;
        cnt_step = 0;
        signal_in = 1;
        for (int i = 0; i < 4; i++) cycle();
        check("rstq.in_qual", int'(stable), 0);
        reset = 1;
        signal_in = 0;
        cycle();
        reset = 0;
        check("rstq.stable", int'(stable), 1);
        check("rstq.out", int'(signal_out), 0);
        check("rstq.glitch", int'(glitch_cnt), 0);
        check("rstq.pulses", int'(rise_pulse | fall_pulse), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) signal_in = ~signal_in;
            cnt_step = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) cnt_size = CNTR_NBITS'($urandom_range(0, 6));
            glitch_clr = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sig_debounce.md
Name: sig_debounce

Overview:
- Front-end conditioning stage for asynchronous board status inputs such as power-good, presence and button lines.
- Synchronises the raw pin into the clk domain, rejects glitches shorter than a programmable qualification time, and emits a clean level plus one-cycle edge pulses.
- Its signal_out drives the signal_in of the downstream edge-delay stage, and both stages share the same cnt_step tick.
- Also keeps a saturating count of rejected glitches for CPLD register readback.

Parameters:
- CNTR_NBITS, 5: width of the qualification counter and of cnt_size.
- DEF_OUTPUT, 1'b0: reset value of the sync chain and of signal_out.
- SYNC_STAGES, 2: number of synchroniser flops. Legal range 2..4.
- GLITCH_NBITS, 8: width of glitch_cnt.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cnt_size  input  CNTR_NBITS  qualification length, counted in cnt_step events.
- cnt_step  input  1  single-cycle time-base tick.
- signal_in  input  1  raw asynchronous pin.
- glitch_clr  input  1  single-cycle clear of glitch_cnt.
- signal_out  output  1  debounced level (registered).
- rise_pulse  output  1  one-cycle pulse on a qualified 0->1 change of signal_out.
- fall_pulse  output  1  one-cycle pulse on a qualified 1->0 change of signal_out.
- stable  output  1  1 when the FSM is in STABLE.
- glitch_cnt  output  GLITCH_NBITS  saturating count of rejected transitions.

Behaviour:
- Reset is synchronous and active-high, and is sampled only on posedge clk. While reset=1:
  - sync chain = DEF_OUTPUT, signal_out = DEF_OUTPUT
  - timer = 0, rise_pulse = fall_pulse = 0
  - glitch_cnt = 0, FSM = STABLE, stable = 1
- Synchroniser: SYNC_STAGES-deep flop chain on signal_in. The last stage is s. There is no logic between the chain flops.
- FSM has two states, STABLE and QUAL. The timer is CNTR_NBITS wide.
- In STABLE:
  - s==signal_out: stay in STABLE, timer=0.
  - s!=signal_out: go to QUAL, timer=0. No cnt_step is consumed on this entry cycle.
- In QUAL, conditions are evaluated in this priority order:
  1. s==signal_out: go to STABLE, timer=0, increment glitch_cnt (saturating at all-ones).
  2. cnt_step=1 and timer>=cnt_size: signal_out<=s, fire the matching rise_pulse or fall_pulse for exactly one cycle (same edge on which signal_out changes), go to STABLE, timer=0.
  3. cnt_step=1 otherwise: timer<=timer+1.
  4. cnt_step=0: hold.
- The comparison uses >= so that lowering cnt_size mid-qualification never causes a wrap. cnt_size is sampled live every cycle.
- cnt_size=0: the change is accepted on the first cnt_step after entering QUAL.
- Latency from a signal_in edge to signal_out is SYNC_STAGES cycles, plus 1 cycle to enter QUAL, plus (cnt_size+1) cnt_step events.
- glitch_clr=1 forces glitch_cnt=0. This wins over a same-cycle increment.
- Saturated glitch_cnt holds its value until glitch_clr or reset.
- rise_pulse and fall_pulse are never both 1 and are never asserted on reset release.
- stable = (state==STABLE) and is registered-state derived.
- cnt_step held at 1 continuously is legal. Each cycle then counts as one step.
- Reset asserted mid-QUAL: the next cycle shows the full reset state. The partial qualification is discarded and is not counted as a glitch.

Test Plan:
1. Reset release with DEF_OUTPUT=0 and signal_in=0: signal_out=0, stable=1, no pulses, glitch_cnt=0 for 100 cycles.
2. cnt_size=3, cnt_step every 4th cycle, signal_in 0->1 held: signal_out rises after 2 sync cycles + 1 cycle + 4 ticks. rise_pulse is high exactly 1 cycle, coincident with the signal_out change. stable=0 during QUAL.
3. cnt_size=3, signal_in high for 2 ticks then back low: signal_out stays 0, no rise_pulse, glitch_cnt=1, stable returns to 1.
4. 260 short glitches with GLITCH_NBITS=8: glitch_cnt saturates at 255. glitch_clr pulsed in the same cycle as a further glitch returns -> glitch_cnt=0.
5. cnt_size=10, timer reaches 6, cnt_size lowered to 2: accept on the next cnt_step, fall_pulse fires on a 1->0 input, no wrap.
6. cnt_size=0 with cnt_step tied to 1, and separately reset asserted mid-QUAL:
   - cnt_size=0 case: signal_out follows in SYNC_STAGES+2 cycles.
   - reset case: outputs return to reset values the next cycle and glitch_cnt is unchanged at 0.
